// File: rtl/chaser_array.sv
// chaser_array: N_PROJ independent projectiles that home on a target point.
// Each channel waits a staggered delay, chases the target one STEP per tick,
// pulses hit on collision, freezes for HIT_HOLD ticks, then respawns.
// Optional build macro: CHASER_LIFETIME_EN adds a forced respawn after
// LIFETIME chase ticks without a hit.
module chaser_array #(
  parameter int N_PROJ      = 4,
  parameter int COORD_W     = 9,
  parameter int STEP        = 1,
  parameter int SPAWN_X     = 100,
  parameter int SPAWN_DX    = 40,
  parameter int SPAWN_Y     = 50,
  parameter int SPAWN_DELAY = 60,
  parameter int HIT_R       = 4,
  parameter int HIT_HOLD    = 30,
  parameter int LIFETIME    = 600
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        tick,
  input  logic                        kill,
  input  logic [COORD_W-1:0]          target_x,
  input  logic [COORD_W-1:0]          target_y,
  output logic [N_PROJ*COORD_W-1:0]   proj_x,
  output logic [N_PROJ*COORD_W-1:0]   proj_y,
  output logic [N_PROJ-1:0]           active,
  output logic [N_PROJ-1:0]           hit,
  output logic                        hit_any
);

  // One counter per channel serves the spawn delay, the hit hold and (when
  // enabled) the lifetime; it is sized for the largest value any build loads
  // so the width does not change with the build macro.
  localparam int DLY_MAX  = N_PROJ * SPAWN_DELAY;
  localparam int MAX_A    = (DLY_MAX > HIT_HOLD) ? DLY_MAX : HIT_HOLD;
  localparam int CNT_MAX  = (MAX_A > LIFETIME) ? MAX_A : LIFETIME;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [COORD_W-1:0] STEP_C    = COORD_W'(STEP);
  localparam logic [COORD_W-1:0] HIT_R_C   = COORD_W'(HIT_R);
  localparam logic [COORD_W-1:0] SPAWN_Y_C = COORD_W'(SPAWN_Y);
  localparam logic [CNT_W-1:0]   ONE_C     = CNT_W'(1);
  localparam logic [CNT_W-1:0]   ZERO_C    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   HOLD_C    = CNT_W'(HIT_HOLD);
  localparam logic [CNT_W-1:0]   RESPAWN_C = CNT_W'(SPAWN_DELAY);
`ifdef CHASER_LIFETIME_EN
  localparam logic [CNT_W-1:0]   LIFE_C    = CNT_W'(LIFETIME);
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHASE = 2'd1,
    ST_HIT   = 2'd2
  } state_e;

  // Unsigned distance, compare first so the subtraction never wraps.
  function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    logic [COORD_W-1:0] r;
    if (a >= b) r = a - b;
    else        r = b - a;
    return r;
  endfunction

  // One STEP toward tgt, clamped so the move lands on tgt instead of passing it.
  function automatic logic [COORD_W-1:0] step_toward(input logic [COORD_W-1:0] pos,
                                                     input logic [COORD_W-1:0] tgt);
    logic [COORD_W-1:0] d;
    logic [COORD_W-1:0] r;
    d = {COORD_W{1'b0}};
    if (tgt > pos) begin
      d = tgt - pos;
      if (d <= STEP_C) r = tgt;
      else             r = pos + STEP_C;
    end else if (tgt < pos) begin
      d = pos - tgt;
      if (d <= STEP_C) r = tgt;
      else             r = pos - STEP_C;
    end else begin
      r = pos;
    end
    return r;
  endfunction

  logic [N_PROJ-1:0] hit_set;
  logic              hit_any_q;

  for (genvar i = 0; i < N_PROJ; i++) begin : g_ch
    localparam logic [COORD_W-1:0] SPAWN_XI = COORD_W'(SPAWN_X + i * SPAWN_DX);
    localparam logic [CNT_W-1:0]   DLY_INIT = CNT_W'((i + 1) * SPAWN_DELAY);

    state_e             state_q;
    logic [COORD_W-1:0] px_q;
    logic [COORD_W-1:0] py_q;
    logic [COORD_W-1:0] px_d;
    logic [COORD_W-1:0] py_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               active_q;
    logic               hit_q;
    logic               collide_d;
    logic               hit_d;

    // Candidate move and collision test, both on the registered position.
    always_comb begin
      px_d      = step_toward(px_q, target_x);
      py_d      = step_toward(py_q, target_y);
      collide_d = (abs_diff(target_x, px_q) <= HIT_R_C) &&
                  (abs_diff(target_y, py_q) <= HIT_R_C);
      if ((state_q == ST_CHASE) && !kill) hit_d = collide_d;
      else                                hit_d = 1'b0;
    end

    // Channel FSM: spawn delay, chase, hit hold; kill restarts like reset.
    always_ff @(posedge clock) begin
      if (reset || kill) begin
        state_q  <= ST_IDLE;
        px_q     <= SPAWN_XI;
        py_q     <= SPAWN_Y_C;
        cnt_q    <= DLY_INIT;
        active_q <= 1'b0;
        hit_q    <= 1'b0;
      end else begin
        hit_q <= 1'b0;
        case (state_q)
          ST_IDLE: begin
            if (tick) begin
              if (cnt_q <= ONE_C) begin
                state_q  <= ST_CHASE;
                active_q <= 1'b1;
`ifdef CHASER_LIFETIME_EN
                cnt_q    <= LIFE_C;
`else
                cnt_q    <= ZERO_C;
`endif
              end else begin
                cnt_q <= cnt_q - ONE_C;
              end
            end else begin
              cnt_q <= cnt_q;
            end
          end
          ST_CHASE: begin
            // A collision freezes the position even when tick is high.
            if (collide_d) begin
              state_q <= ST_HIT;
              hit_q   <= 1'b1;
              cnt_q   <= HOLD_C;
            end else if (tick) begin
`ifdef CHASER_LIFETIME_EN
              if (cnt_q <= ONE_C) begin
                state_q  <= ST_IDLE;
                px_q     <= SPAWN_XI;
                py_q     <= SPAWN_Y_C;
                cnt_q    <= RESPAWN_C;
                active_q <= 1'b0;
              end else begin
                cnt_q <= cnt_q - ONE_C;
                px_q  <= px_d;
                py_q  <= py_d;
              end
`else
              px_q <= px_d;
              py_q <= py_d;
`endif
            end else begin
              px_q <= px_q;
            end
          end
          ST_HIT: begin
            if (tick) begin
              if (cnt_q <= ONE_C) begin
                state_q  <= ST_IDLE;
                px_q     <= SPAWN_XI;
                py_q     <= SPAWN_Y_C;
                cnt_q    <= RESPAWN_C;
                active_q <= 1'b0;
              end else begin
                cnt_q <= cnt_q - ONE_C;
              end
            end else begin
              cnt_q <= cnt_q;
            end
          end
          default: begin
            state_q  <= ST_IDLE;
            px_q     <= SPAWN_XI;
            py_q     <= SPAWN_Y_C;
            cnt_q    <= RESPAWN_C;
            active_q <= 1'b0;
          end
        endcase
      end
    end

    assign hit_set[i]                    = hit_d;
    assign proj_x[i*COORD_W +: COORD_W]  = px_q;
    assign proj_y[i*COORD_W +: COORD_W]  = py_q;
    assign active[i]                     = active_q;
    assign hit[i]                        = hit_q;
  end

  // Registered OR of the per-channel hit pulses, aligned with hit.
  always_ff @(posedge clock) begin
    if (reset) hit_any_q <= 1'b0;
    else       hit_any_q <= |hit_set;
  end

  assign hit_any = hit_any_q;

endmodule

// File: doc/chaser_array.md
Name: chaser_array

Overview:
- Parametrised multi-projectile tracker.
- Drives N_PROJ independent projectiles that home on a target (character) position.
- Each channel spawns on a staggered schedule, detects its own hit, and respawns after a hold time.
- Sits between the game-state logic (character position, die/restart) and the raster compositor, which reads the flattened positions.

Parameters:
- N_PROJ, 4, number of projectile channels (1..8).
- COORD_W, 9, coordinate width in bits.
- STEP, 1, max pixels moved per axis per tick.
- SPAWN_X, 100, x spawn of channel 0.
- SPAWN_DX, 40, x spacing between channel spawn points.
- SPAWN_Y, 50, y spawn for all channels.
- SPAWN_DELAY, 60, ticks per stagger slot; channel i waits (i+1)*SPAWN_DELAY ticks.
- HIT_R, 4, hit box half-size in pixels.
- HIT_HOLD, 30, ticks a hit channel freezes before respawn.
- LIFETIME, 600, ticks before forced respawn (optional feature only).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tick  in  1  one-cycle movement strobe (from limiter)
- kill  in  1  restart all channels (player died / restart key)
- target_x  in  COORD_W  character x
- target_y  in  COORD_W  character y
- proj_x  out  N_PROJ*COORD_W  flattened x positions; channel i at bits [i*COORD_W +: COORD_W]
- proj_y  out  N_PROJ*COORD_W  flattened y positions, same packing
- active  out  N_PROJ  channel i in CHASE or HIT (compositor draws only active channels)
- hit  out  N_PROJ  one-cycle pulse per channel on collision
- hit_any  out  1  OR of hit, same cycle

Behaviour:
- Interface: one clock, `clock`; reset `reset` is synchronous and active-high.
- Reset state, per channel:
  - state = IDLE; proj = (SPAWN_X + i*SPAWN_DX, SPAWN_Y), truncated to COORD_W.
  - Delay counter = (i+1)*SPAWN_DELAY.
  - active = 0, hit = 0, hit_any = 0.
- kill: same effect as reset, one cycle after assertion. kill has priority over tick and over collision.
- IDLE:
  - Each tick decrements the delay counter.
  - When the counter reaches 0 on a tick, go to CHASE; active = 1 from the next cycle.
- CHASE movement (on tick), per axis independently:
  - Target > pos: pos += min(STEP, target - pos).
  - Target < pos: pos -= min(STEP, pos - target).
  - Equal: hold.
  - Never overshoots and never wraps. Differences are computed unsigned with a compare-first rule.
- Collision:
  - Evaluated every clock in CHASE on registered positions: |target_x - px| <= HIT_R and |target_y - py| <= HIT_R.
  - On a match, the channel goes to HIT and hit[i] pulses for exactly one cycle, in the cycle after the match.
  - The position is not updated in a cycle where a collision is detected, even if tick is high.
- HIT:
  - Position frozen; active stays 1.
  - Hold counter loads HIT_HOLD on entry and decrements on tick.
  - At 0: go to IDLE, position reloads to spawn, delay counter reloads to SPAWN_DELAY (single slot, not staggered).
- Latency: tick in cycle n, new position visible in cycle n+1. Target changes affect movement from the next tick.
- Simultaneous hits: multiple channels may pulse in the same cycle; hit_any = 1 for that one cycle.
- Counters are sized to hold their maximum load value.
- A tick while already at the target produces no change. Target outside the screen is followed without special-casing.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: CHASER_LIFETIME_EN.
- When defined, each CHASE channel has a lifetime counter:
  - Loaded with LIFETIME on entry to CHASE; decremented per tick.
  - At 0: channel goes to IDLE, respawns, reloads SPAWN_DELAY, with no hit pulse.
  - If a collision and expiry occur in the same cycle, the collision wins.
- When not defined, there is no lifetime counter; channels chase until hit or kill.

Test Plan:
- Reset with defaults, then 59 ticks → all active = 0. On tick 60, active = 4'b0001 from the next cycle. active = 4'b0011 after tick 120.
- Channel 0 chasing, target (110,60), channel 0 at (100,50), STEP=1 → after 5 ticks pos (105,55); hit pulses when pos reaches (106,56).
- STEP=3, target 2 px right of proj x → x advances by 2 only and stays put thereafter (no overshoot).
- Collision with tick high in the same cycle → position unchanged; hit[0] = 1 for one cycle; 30 ticks later active[0] = 0 and pos = (100,50); active again 60 ticks after that.
- kill asserted during HIT on ch0 and CHASE on ch1 → next cycle all active = 0, all at spawn (100,50),(140,50),…; stagger restarts from 60.
- With CHASER_LIFETIME_EN and LIFETIME=10, target unreachable → channel respawns after 10 chase ticks with no hit pulse.
